// File: rtl/conv_sched.sv
`default_nettype none
// ============================================================================
//  Module   : conv_sched
//  Brief    : Per-layer convolution scheduler. Tracks pixels written by the
//             previous layer, detects complete kernel windows and sequences
//             ctrl load -> CIM execute -> func for each window.
//  Revision : 1.0  initial release
// ============================================================================
module conv_sched #(
    parameter  int IMG_WIDTH  = 28,
    parameter  int KERNEL_DIM = 3,
    localparam int OUT_DIM    = IMG_WIDTH - KERNEL_DIM + 1,
    localparam int CNT_W      = $clog2(IMG_WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_layer_start,
    input  logic             i_pixel_we,
    output logic             o_stall,
    output logic             o_ctrl_start,
    input  logic             i_ctrl_busy,
    output logic             o_cim_start,
    input  logic             i_cim_busy,
    output logic             o_func_start,
    input  logic             i_func_busy,
    output logic [CNT_W-1:0] o_out_row,
    output logic [CNT_W-1:0] o_out_col,
    output logic             o_busy,
    output logic             o_layer_done,
    output logic             o_overrun
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_wait_pix = 3'd1;
    localparam logic [2:0] c_st_issue_ld = 3'd2;
    localparam logic [2:0] c_st_load     = 3'd3;
    localparam logic [2:0] c_st_issue_ex = 3'd4;
    localparam logic [2:0] c_st_exec     = 3'd5;
    localparam logic [2:0] c_st_issue_fn = 3'd6;
    localparam logic [2:0] c_st_drain    = 3'd7;

    localparam logic [CNT_W-1:0] c_last_col = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_k1       = CNT_W'(KERNEL_DIM - 1);
    localparam logic [CNT_W-1:0] c_last_out = CNT_W'(OUT_DIM - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_seen;      // watched busy has been sampled high in this state
    logic             r_pending;   // a captured window is waiting for its load
    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_out_row;
    logic [CNT_W-1:0] r_out_col;
    logic             r_overrun;

    logic w_arm;
    logic w_accept;
    logic w_trigger;
    logic w_drop;
    logic w_watch_busy;
    logic w_last_win;

    assign w_arm      = (r_state == c_st_idle) && i_layer_start;
    assign w_accept   = i_pixel_we && !o_stall && (r_state != c_st_idle);
    assign w_drop     = i_pixel_we && o_stall;
    assign w_trigger  = w_accept && (r_row >= c_k1) && (r_col >= c_k1);
    assign w_last_win = (r_out_row == c_last_out) && (r_out_col == c_last_out);

    // Busy line whose 1-then-0 handshake ends the current wait state
    always_comb begin
        w_watch_busy = 1'b0;
        case (r_state)
            c_st_load:  w_watch_busy = i_ctrl_busy;
            c_st_exec:  w_watch_busy = i_cim_busy;
            c_st_drain: w_watch_busy = i_func_busy;
            default:    w_watch_busy = 1'b0;
        endcase
    end

    // State register plus the busy-seen flag, which restarts on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_seen  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_seen  <= (w_next != r_state) ? 1'b0 : (r_seen || w_watch_busy);
        end
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:     if (i_layer_start) w_next = c_st_wait_pix;
            c_st_wait_pix: if (r_pending) w_next = c_st_issue_ld;
            c_st_issue_ld: if (!i_ctrl_busy && !i_cim_busy) w_next = c_st_load;
            c_st_load:     if (r_seen && !i_ctrl_busy) w_next = c_st_issue_ex;
            c_st_issue_ex: if (!i_func_busy && !i_cim_busy) w_next = c_st_exec;
            c_st_exec:     if (r_seen && !i_cim_busy) w_next = c_st_issue_fn;
            c_st_issue_fn: begin
                // A pending window means the one in flight cannot be the last
                if (!i_func_busy) begin
                    if (r_pending || w_trigger) w_next = c_st_issue_ld;
                    else if (w_last_win)        w_next = c_st_drain;
                    else                        w_next = c_st_wait_pix;
                end
            end
            c_st_drain:    if (r_seen && !i_func_busy) w_next = c_st_idle;
            default:       w_next = c_st_idle;
        endcase
    end

    // Outputs: stall covers idle, the load phase and any captured-but-unloaded window
    always_comb begin
        o_stall      = (r_state == c_st_idle) || (r_state == c_st_issue_ld) ||
                       (r_state == c_st_load) || r_pending;
        o_ctrl_start = (r_state == c_st_issue_ld) && !i_ctrl_busy && !i_cim_busy;
        o_cim_start  = (r_state == c_st_issue_ex) && !i_func_busy && !i_cim_busy;
        o_func_start = (r_state == c_st_issue_fn) && !i_func_busy;
        o_layer_done = (r_state == c_st_drain) && r_seen && !i_func_busy;
        o_busy       = (r_state != c_st_idle);
    end

    assign o_out_row = r_out_row;
    assign o_out_col = r_out_col;
    assign o_overrun = r_overrun;

    // Pixel position tracking, window capture and overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row     <= '0;
            r_col     <= '0;
            r_pending <= 1'b0;
            r_out_row <= '0;
            r_out_col <= '0;
            r_overrun <= 1'b0;
        end else if (w_arm) begin
            r_row     <= '0;
            r_col     <= '0;
            r_pending <= 1'b0;
            r_out_row <= '0;
            r_out_col <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_col == c_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_trigger) begin
                r_pending <= 1'b1;
                r_out_row <= r_row - c_k1;
                r_out_col <= r_col - c_k1;
            end else if (o_ctrl_start) begin
                r_pending <= 1'b0;
            end
            if (w_drop) r_overrun <= 1'b1;
        end
    end

endmodule
`default_nettype wire
